// File: rtl/reg_file_ops.sv
// -----------------------------------------------------------------------------
// reg_file_ops
//   General-purpose register file with DEPTH registers of WIDTH bits each.
//   Two combinational read ports supply the operand-select mux (A -> in0,
//   B -> in1). One write port applies a per-cycle register function to a
//   single addressed register on the rising clock edge.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset: clears every register and wrap
//   wr_en      1 = apply funsel to register wr_addr on this edge
//   wr_addr    target register index
//   funsel     00 clear, 01 load wr_data, 10 increment, 11 decrement
//   wr_data    load value (used only for funsel = 01)
//   rd_addr_a  read port A index
//   rd_addr_b  read port B index
//   out_a      reg[rd_addr_a], combinational
//   out_b      reg[rd_addr_b], combinational
//   wrap       one-cycle registered pulse: the last edge's inc/dec wrapped
// -----------------------------------------------------------------------------
module reg_file_ops #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        funsel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic              wrap
);

    localparam logic [1:0] FN_CLR = 2'b00;
    localparam logic [1:0] FN_LD  = 2'b01;
    localparam logic [1:0] FN_INC = 2'b10;
    localparam logic [1:0] FN_DEC = 2'b11;

    // Flattened view of every register, gathered from the per-register blocks.
    logic [WIDTH-1:0] w_regs [DEPTH];

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    logic             r_wrap;

    // Only one register is written per edge, so the function unit is shared
    // and operates on the currently addressed register.
    assign w_cur = w_regs[wr_addr];

    always_comb begin
        w_next      = w_cur;
        w_wrap_next = 1'b0;
        case (funsel)
            FN_CLR: w_next = '0;
            FN_LD:  w_next = wr_data;
            FN_INC: begin
                w_next      = w_cur + WIDTH'(1);
                w_wrap_next = (w_cur == {WIDTH{1'b1}});
            end
            FN_DEC: begin
                w_next      = w_cur - WIDTH'(1);
                w_wrap_next = (w_cur == '0);
            end
            default: w_next = w_cur;
        endcase
    end

    // One flop bank per register; each only captures when it is addressed.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    r_q <= w_next;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    // wrap is re-evaluated on every edge, so it self-clears after one cycle
    // and is 0 on idle, clear and load edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= wr_en & w_wrap_next;
        end
    end

    // No write bypass: reads see the array contents before the edge.
    assign out_a = w_regs[rd_addr_a];
    assign out_b = w_regs[rd_addr_b];
    assign wrap  = r_wrap;

endmodule
